// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider, one shift-subtract-restore step per clock.
// Optional macro RESTDIV_DIVZERO_CHECK_EN: short-circuit divide-by-zero and flag it.
module restoring_divider_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // R's top bit is always zero after a restore step, so only the low
    // WIDTH bits are stored; the shifted value below is WIDTH+1 wide.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   t_shift;
    logic [WIDTH:0]   d_diff;
    logic             qbit;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] r_d;

    assign t_shift = {r_q, a_q[WIDTH-1]};
    assign d_diff  = t_shift - {1'b0, b_q};
    assign qbit    = ~d_diff[WIDTH];
    assign r_d     = qbit ? d_diff[WIDTH-1:0] : t_shift[WIDTH-1:0];
    assign a_d     = {a_q[WIDTH-2:0], qbit};

`ifdef RESTDIV_DIVZERO_CHECK_EN
    logic dz_q;

    // Divide-by-zero flag: set on a zero-divisor accept, cleared on the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            dz_q <= (divisor == '0);
        end
    end

    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    // Control FSM plus datapath registers; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        r_q   <= '0;
                        cnt_q <= '0;
`ifdef RESTDIV_DIVZERO_CHECK_EN
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    a_q <= a_d;
                    r_q <= r_d;
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= a_d;
                        remainder_q <= r_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed testbench for restoring_divider_seq (WIDTH=8).
// Handles both builds of RESTDIV_DIVZERO_CHECK_EN.
module tb_restoring_divider_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int errors;
    int checks;

    restoring_divider_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count edges (start edge = 1) until done, then one more edge.
    task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         output int lat, output int bcyc,
                         output bit overlap, output bit done_after);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        tick();
        start   = 1'b0;
        lat     = 1;
        bcyc    = busy ? 1 : 0;
        overlap = busy && done;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) bcyc++;
            if (busy && done) overlap = 1'b1;
        end
        if (!done) lat = -1;
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (quotient !== 8'd0) begin
            errors++; $display("FAIL reset_q got=%0d exp=0", quotient);
        end
        checks++;
        if (remainder !== 8'd0) begin
            errors++; $display("FAIL reset_r got=%0d exp=0", remainder);
        end
        checks++;
        if (div_zero !== 1'b0) begin
            errors++; $display("FAIL reset_dz got=%b exp=0", div_zero);
        end
    endtask

    task automatic test_basic();
        int lat, bcyc;
        bit ov, da;
        do_op(8'd100, 8'd7, lat, bcyc, ov, da);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL basic_latency got=%0d exp=9", lat);
        end
        checks++;
        if (bcyc !== 8) begin
            errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcyc);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++; $display("FAIL basic_busy_done_overlap got=%b exp=0", ov);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++; $display("FAIL basic_done_one_cycle got=%b exp=0", da);
        end
        checks++;
        if (quotient !== 8'd14) begin
            errors++; $display("FAIL basic_q got=%0d exp=14", quotient);
        end
        checks++;
        if (remainder !== 8'd2) begin
            errors++; $display("FAIL basic_r got=%0d exp=2", remainder);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] vd [4] = '{8'd255, 8'd5, 8'd200, 8'd0};
        logic [W-1:0] vs [4] = '{8'd1,   8'd9, 8'd200, 8'd3};
        logic [W-1:0] vq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [W-1:0] vr [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int lat, bcyc;
        bit ov, da;
        for (int i = 0; i < 4; i++) begin
            do_op(vd[i], vs[i], lat, bcyc, ov, da);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL vec%0d_latency got=%0d exp=9", i, lat);
            end
            checks++;
            if (quotient !== vq[i]) begin
                errors++;
                $display("FAIL vec%0d_q got=%0d exp=%0d", i, quotient, vq[i]);
            end
            checks++;
            if (remainder !== vr[i]) begin
                errors++;
                $display("FAIL vec%0d_r got=%0d exp=%0d", i, remainder, vr[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        lat      = 1;
        dividend = 8'd50;
        divisor  = 8'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL ignore_latency got=%0d exp=9", lat);
        end
        checks++;
        if (quotient !== 8'd14) begin
            errors++; $display("FAIL ignore_q got=%0d exp=14", quotient);
        end
        checks++;
        if (remainder !== 8'd2) begin
            errors++; $display("FAIL ignore_r got=%0d exp=2", remainder);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcyc, npulse;
        bit ov, da;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy got=%b exp=0", busy);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_qr got=%0d/%0d exp=0/0", quotient, remainder);
        end
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) npulse++;
            tick();
        end
        checks++;
        if (npulse !== 0) begin
            errors++; $display("FAIL rstmid_no_done got=%0d exp=0", npulse);
        end
        do_op(8'd9, 8'd2, lat, bcyc, ov, da);
        checks++;
        if (quotient !== 8'd4) begin
            errors++; $display("FAIL rstmid_fresh_q got=%0d exp=4", quotient);
        end
        checks++;
        if (remainder !== 8'd1) begin
            errors++; $display("FAIL rstmid_fresh_r got=%0d exp=1", remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        bit ov, da;
`ifdef RESTDIV_DIVZERO_CHECK_EN
        int exp_lat = 1;
        logic exp_dz = 1'b1;
`else
        int exp_lat = 9;
        logic exp_dz = 1'b0;
`endif
        do_op(8'd77, 8'd0, lat, bcyc, ov, da);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL dz_latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (quotient !== 8'd255) begin
            errors++; $display("FAIL dz_q got=%0d exp=255", quotient);
        end
        checks++;
        if (remainder !== 8'd77) begin
            errors++; $display("FAIL dz_r got=%0d exp=77", remainder);
        end
        checks++;
        if (div_zero !== exp_dz) begin
            errors++; $display("FAIL dz_flag_held got=%b exp=%b", div_zero, exp_dz);
        end
        do_op(8'd9, 8'd2, lat, bcyc, ov, da);
        checks++;
        if (div_zero !== 1'b0) begin
            errors++; $display("FAIL dz_flag_cleared got=%b exp=0", div_zero);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, edge_n;
        bit ov;
        logic [W-1:0] q2, r2;
        first  = -1;
        second = -1;
        ov     = 1'b0;
        q2     = '0;
        r2     = '0;
        edge_n = 0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        while (second < 0 && edge_n < 40) begin
            tick();
            edge_n++;
            if (busy && done) ov = 1'b1;
            if (done) begin
                if (first < 0) begin
                    first = edge_n;
                end else begin
                    second = edge_n;
                    q2 = quotient;
                    r2 = remainder;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first !== 9) begin
            errors++; $display("FAIL b2b_first got=%0d exp=9", first);
        end
        checks++;
        if (second - first !== 10) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=10", second - first);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++; $display("FAIL b2b_overlap got=%b exp=0", ov);
        end
        checks++;
        if (q2 !== 8'd14 || r2 !== 8'd2) begin
            errors++; $display("FAIL b2b_result got=%0d/%0d exp=14/2", q2, r2);
        end
        tick();
        tick();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_div_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
